wb_regfile: RTL and testbench

- Write-back end of the MEM/WB interface: consumes the registered WB-side bundle and commits it to architectural state.
- Holds the 32-entry GPR file, the HI/LO pair and the LLbit.
- Returns committed and same-cycle-bypassed values to ID (GPR reads) and MEM (HI/LO, LLbit).
- Sits directly after the MEM/WB pipeline register; no logic between them.

---
 rtl/wb_regfile.sv | 70 +++++++
 tb/tb_wb_regfile.sv | 184 ++++++++++++++++++
 2 files changed

// File: rtl/wb_regfile.sv
// wb_regfile: write-back commit of the MEM/WB bundle into GPRs, HI/LO and LLbit,
// with same-cycle bypass to ID/MEM and a retire counter.
module wb_regfile #(
  parameter int DATA_W  = 32,
  parameter int ADDR_W  = 5,
  parameter int REG_NUM = 32,
  parameter int CNT_W   = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] wb_wd,
  input  logic              wb_wreg,
  input  logic [DATA_W-1:0] wb_wdata,
  input  logic [DATA_W-1:0] wb_hi,
  input  logic [DATA_W-1:0] wb_lo,
  input  logic              wb_whilo,
  input  logic              wb_LLbit_we,
  input  logic              wb_LLbit_value,
  input  logic              flush,
  input  logic              re1,
  input  logic [ADDR_W-1:0] raddr1,
  output logic [DATA_W-1:0] rdata1,
  input  logic              re2,
  input  logic [ADDR_W-1:0] raddr2,
  output logic [DATA_W-1:0] rdata2,
  output logic [DATA_W-1:0] hi_o,
  output logic [DATA_W-1:0] lo_o,
  output logic [DATA_W-1:0] hi_fwd,
  output logic [DATA_W-1:0] lo_fwd,
  output logic              LLbit_o,
  output logic              LLbit_fwd,
  output logic [CNT_W-1:0]  retire_cnt
);
  logic [DATA_W-1:0] gpr [REG_NUM];
  logic [DATA_W-1:0] hi, lo;
  logic              ll;
  logic              gpr_we, ll_we, commit;
  assign gpr_we = wb_wreg && wb_wd != '0;
  assign ll_we  = wb_LLbit_we && !flush;
  assign commit = gpr_we || wb_whilo || ll_we;
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < REG_NUM; i++) gpr[i] <= '0;
      hi         <= '0;
      lo         <= '0;
      ll         <= 1'b0;
      retire_cnt <= '0;
    end else begin
      if (gpr_we) gpr[wb_wd] <= wb_wdata;
      if (wb_whilo) begin
        hi <= wb_hi;
        lo <= wb_lo;
      end
      if (flush) ll <= 1'b0;
      else if (wb_LLbit_we) ll <= wb_LLbit_value;
      if (commit) retire_cnt <= retire_cnt + CNT_W'(1);
    end
  end
  // bypass paths are gated by rst so nothing leaks out while held in reset
  assign rdata1 = (!rst || !re1 || raddr1 == '0) ? '0 :
                  (wb_wreg && raddr1 == wb_wd) ? wb_wdata : gpr[raddr1];
  assign rdata2 = (!rst || !re2 || raddr2 == '0) ? '0 :
                  (wb_wreg && raddr2 == wb_wd) ? wb_wdata : gpr[raddr2];
  assign hi_o      = hi;
  assign lo_o      = lo;
  assign hi_fwd    = !rst ? '0 : wb_whilo ? wb_hi : hi;
  assign lo_fwd    = !rst ? '0 : wb_whilo ? wb_lo : lo;
  assign LLbit_o   = ll;
  assign LLbit_fwd = rst && !flush && (wb_LLbit_we ? wb_LLbit_value : ll);
endmodule

// File: tb/tb_wb_regfile.sv
// tb_wb_regfile: directed plan steps plus random bundles checked against a behavioural model.
module tb_wb_regfile;
  localparam int CW = 4;
  logic          clk = 1'b0;
  logic          rst;
  logic [4:0]    wb_wd, raddr1, raddr2;
  logic          wb_wreg, wb_whilo, wb_LLbit_we, wb_LLbit_value, flush, re1, re2;
  logic [31:0]   wb_wdata, wb_hi, wb_lo;
  logic [31:0]   rdata1, rdata2, hi_o, lo_o, hi_fwd, lo_fwd;
  logic          LLbit_o, LLbit_fwd;
  logic [CW-1:0] retire_cnt;
  logic [31:0]   m_gpr [32];
  logic [31:0]   m_hi, m_lo;
  logic          m_ll;
  int            m_cnt;
  int            n_chk = 0, n_fail = 0;

  wb_regfile #(.CNT_W(CW)) dut (
    .clk(clk), .rst(rst), .wb_wd(wb_wd), .wb_wreg(wb_wreg), .wb_wdata(wb_wdata),
    .wb_hi(wb_hi), .wb_lo(wb_lo), .wb_whilo(wb_whilo), .wb_LLbit_we(wb_LLbit_we),
    .wb_LLbit_value(wb_LLbit_value), .flush(flush), .re1(re1), .raddr1(raddr1),
    .rdata1(rdata1), .re2(re2), .raddr2(raddr2), .rdata2(rdata2), .hi_o(hi_o),
    .lo_o(lo_o), .hi_fwd(hi_fwd), .lo_fwd(lo_fwd), .LLbit_o(LLbit_o),
    .LLbit_fwd(LLbit_fwd), .retire_cnt(retire_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 32; i++) m_gpr[i] = '0;
    m_hi = '0;
    m_lo = '0;
    m_ll = 1'b0;
    m_cnt = 0;
  endtask

  function automatic logic [31:0] exp_rd(input logic re, input logic [4:0] a);
    if (!rst || !re || a == 0) return '0;
    if (wb_wreg && a == wb_wd) return wb_wdata;
    return m_gpr[a];
  endfunction

  task automatic check_all();
    logic z;
    z = !rst;
    chk("rdata1", rdata1, exp_rd(re1, raddr1));
    chk("rdata2", rdata2, exp_rd(re2, raddr2));
    chk("hi_o", hi_o, m_hi);
    chk("lo_o", lo_o, m_lo);
    chk("hi_fwd", hi_fwd, z ? 32'd0 : wb_whilo ? wb_hi : m_hi);
    chk("lo_fwd", lo_fwd, z ? 32'd0 : wb_whilo ? wb_lo : m_lo);
    chk("LLbit_o", 32'(LLbit_o), 32'(m_ll));
    chk("LLbit_fwd", 32'(LLbit_fwd), z ? 32'd0 : flush ? 32'd0 : 32'(wb_LLbit_we ? wb_LLbit_value : m_ll));
    chk("retire_cnt", 32'(retire_cnt), 32'(m_cnt % (1 << CW)));
  endtask

  task automatic model_commit();
    bit any;
    if (!rst) return;
    any = 0;
    if (wb_wreg && wb_wd != 0) begin m_gpr[wb_wd] = wb_wdata; any = 1; end
    if (wb_whilo) begin m_hi = wb_hi; m_lo = wb_lo; any = 1; end
    if (flush) m_ll = 1'b0;
    else if (wb_LLbit_we) begin m_ll = wb_LLbit_value; any = 1; end
    if (any) m_cnt++;
  endtask

  task automatic cycle();
    #1 check_all();
    @(posedge clk);
    model_commit();
    @(negedge clk);
  endtask

  task automatic idle();
    wb_wd = '0; wb_wreg = 0; wb_wdata = '0; wb_hi = '0; wb_lo = '0;
    wb_whilo = 0; wb_LLbit_we = 0; wb_LLbit_value = 0; flush = 0;
  endtask

  task automatic rand_bundle();
    wb_wd = 5'($urandom); wb_wreg = 1'($urandom); wb_wdata = $urandom;
    wb_hi = $urandom; wb_lo = $urandom; wb_whilo = ($urandom_range(3) == 0);
    wb_LLbit_we = 1'($urandom); wb_LLbit_value = 1'($urandom);
    flush = ($urandom_range(5) == 0);
    re1 = ($urandom_range(7) != 0); re2 = ($urandom_range(7) != 0);
    raddr1 = ($urandom_range(2) == 0) ? wb_wd : 5'($urandom);
    raddr2 = ($urandom_range(3) == 0) ? raddr1 : 5'($urandom);
  endtask

  initial begin
    rst = 0;
    model_reset();
    idle();
    re1 = 1; re2 = 1; raddr1 = 3; raddr2 = 0;
    // busy bundle while held in reset: nothing may commit or bypass
    wb_wreg = 1; wb_wd = 3; wb_wdata = 32'hA5A5A5A5; wb_whilo = 1; wb_hi = 7; wb_lo = 9;
    wb_LLbit_we = 1; wb_LLbit_value = 1;
    cycle();
    cycle();
    idle();
    rst = 1;
    #1 check_all();
    for (int a = 1; a < 32; a++) begin
      raddr1 = 5'(a); raddr2 = 5'(32 - a);
      #1 chk("reset_rd1", rdata1, 32'd0);
      chk("reset_rd2", rdata2, 32'd0);
    end
    chk("reset_cnt", 32'(retire_cnt), 32'd0);
    @(negedge clk);
    wb_wreg = 1; wb_wd = 5; wb_wdata = 32'hDEADBEEF; raddr1 = 5;
    #1 chk("r5_bypass", rdata1, 32'hDEADBEEF);
    cycle();
    idle();
    #1 chk("r5_stored", rdata1, 32'hDEADBEEF);
    chk("cnt_after_r5", 32'(retire_cnt), 32'd1);
    wb_wreg = 1; wb_wd = 0; wb_wdata = 32'h1234; raddr2 = 0;
    cycle();
    idle();
    #1 chk("r0_zero", rdata2, 32'd0);
    chk("cnt_r0_nop", 32'(retire_cnt), 32'd1);
    wb_whilo = 1; wb_hi = 32'h11; wb_lo = 32'h22;
    #1 chk("hi_fwd_same", hi_fwd, 32'h11);
    chk("lo_fwd_same", lo_fwd, 32'h22);
    chk("hi_o_before", hi_o, 32'd0);
    chk("lo_o_before", lo_o, 32'd0);
    cycle();
    idle();
    #1 chk("hi_o_after", hi_o, 32'h11);
    chk("lo_o_after", lo_o, 32'h22);
    wb_LLbit_we = 1; wb_LLbit_value = 1;
    cycle();
    idle();
    #1 chk("ll_set", 32'(LLbit_o), 32'd1);
    flush = 1; wb_LLbit_we = 1; wb_LLbit_value = 1;
    #1 chk("ll_fwd_flush", 32'(LLbit_fwd), 32'd0);
    cycle();
    idle();
    #1 chk("ll_flushed", 32'(LLbit_o), 32'd0);
    wb_wreg = 1; wb_wd = 7; wb_wdata = 32'h55;
    cycle();
    idle();
    re1 = 1; raddr1 = 7;
    #1 chk("r7_before_rst", rdata1, 32'h55);
    #1 rst = 0;
    #1 chk("r7_async_rst", rdata1, 32'd0);
    chk("hi_async_rst", hi_o, 32'd0);
    chk("cnt_async_rst", 32'(retire_cnt), 32'd0);
    model_reset();
    @(negedge clk);
    rst = 1;
    cycle();
    for (int i = 0; i < 400; i++) begin
      rand_bundle();
      cycle();
    end
    idle();
    while (m_cnt % (1 << CW) != (1 << CW) - 1) begin
      wb_whilo = 1; wb_hi = $urandom; wb_lo = $urandom;
      cycle();
    end
    idle();
    #1 chk("cnt_all_ones", 32'(retire_cnt), 32'hF);
    wb_wreg = 1; wb_wd = 9; wb_wdata = $urandom;
    cycle();
    idle();
    #1 chk("cnt_wrap", 32'(retire_cnt), 32'd0);
    wb_wreg = 1; wb_wd = 10; wb_wdata = $urandom; wb_whilo = 1; wb_hi = 1; wb_lo = 2;
    wb_LLbit_we = 1; wb_LLbit_value = 1;
    cycle();
    idle();
    #1 chk("cnt_multi_plus1", 32'(retire_cnt), 32'd1);
    check_all();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
